rd_busy_scoreboard: RTL and testbench

- Per-unit in-flight destination tracker for the multi-cycle execute units: unit 0 is the integer divider; units 1..N-1 are FP.
- Fills each unit slot when the unit is issued to, and frees it on writeback or on the per-unit clear_rd kill.
- Its registered slot state feeds the WAW clear decoder (rd_used, all_uu_rd_busy, reg_write_unit, FP_reg_write_unit).
- Also produces RAW/WAW hazard flags for the decode/issue stall logic.

---
 rtl/rd_busy_scoreboard_pkg.sv | 36 +++
 rtl/rd_busy_scoreboard_slot.sv | 53 +++++
 rtl/rd_busy_scoreboard.sv | 118 +++++++++++
 tb/tb_rd_busy_scoreboard.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_busy_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// rd_busy_scoreboard_pkg
//   Shared types and constants for the in-flight destination scoreboard.
//   - slot_t      : per-unit tracking state (valid, rd, is_fp, cnt)
//   - NUM_RDS     : default number of tracked execute units
//   - RD_ADDR_WIDTH, LAT_WIDTH : default field widths used by slot_t
//   - DIV_UNIT    : unit index of the integer divider (first slot)
//   - src_match() : class-aware register compare used by the hazard logic
// ---------------------------------------------------------------------------
package rd_busy_scoreboard_pkg;

  localparam int NUM_RDS       = 9;
  localparam int RD_ADDR_WIDTH = 5;
  localparam int LAT_WIDTH     = 5;
  localparam int DIV_UNIT      = 0;

  typedef struct packed {
    logic                     valid;
    logic [RD_ADDR_WIDTH-1:0] rd;
    logic                     is_fp;
    logic [LAT_WIDTH-1:0]     cnt;
  } slot_t;

  // True when a tracked slot destination names the same architectural
  // register as a decode operand. Integer x0 is hardwired, so it never
  // matches; FP f0 is a real register and does.
  function automatic logic src_match(
    input logic [RD_ADDR_WIDTH-1:0] slot_rd,
    input logic                     slot_fp,
    input logic [RD_ADDR_WIDTH-1:0] src,
    input logic                     src_fp
  );
    return (slot_rd == src) && (slot_fp == src_fp) && (src_fp || (src != '0));
  endfunction

endpackage

// File: rtl/rd_busy_scoreboard_slot.sv
// ---------------------------------------------------------------------------
// scoreboard_slot
//   State for one execute-unit slot. An accepted issue has top priority,
//   then a kill (writeback or WAW clear), then the latency countdown.
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     i_load        : issue accepted for this slot this cycle
//     i_kill        : wb_done or clear_rd for this slot
//     i_rd, i_is_fp, i_latency : issued destination and latency
//     o_valid, o_rd, o_is_fp   : registered slot fields
//     o_busy        : slot valid and result not yet at MEM
// ---------------------------------------------------------------------------
module scoreboard_slot
  import rd_busy_scoreboard_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_load,
  input  logic                     i_kill,
  input  logic [RD_ADDR_WIDTH-1:0] i_rd,
  input  logic                     i_is_fp,
  input  logic [LAT_WIDTH-1:0]     i_latency,
  output logic                     o_valid,
  output logic [RD_ADDR_WIDTH-1:0] o_rd,
  output logic                     o_is_fp,
  output logic                     o_busy
);

  slot_t r_slot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= '0;
    end else if (i_load) begin
      // Integer x0 writes are accepted but never tracked.
      r_slot.valid <= i_is_fp || (i_rd != '0);
      r_slot.rd    <= i_rd;
      r_slot.is_fp <= i_is_fp;
      r_slot.cnt   <= i_latency;
    end else if (i_kill) begin
      r_slot.valid <= 1'b0;
      r_slot.cnt   <= '0;
    end else if (r_slot.cnt != '0) begin
      r_slot.cnt   <= r_slot.cnt - 1'b1;
    end
  end

  assign o_valid = r_slot.valid;
  assign o_rd    = r_slot.rd;
  assign o_is_fp = r_slot.is_fp;
  assign o_busy  = r_slot.valid && (r_slot.cnt != '0);

endmodule

// File: rtl/rd_busy_scoreboard.sv
// ---------------------------------------------------------------------------
// rd_busy_scoreboard
//   Tracks the destination register of the instruction in flight in each
//   multi-cycle execute unit (unit 0 = integer divider, 1..N-1 = FP) and
//   flags decode-stage RAW/WAW hazards against that registered state.
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     issue_*               : issue request (unit, rd, class, latency)
//     wb_done, clear_rd     : per-unit writeback / kill
//     rs1..rs3, *_is_fp, rs3_used, new_rd, reg_write_new, FP_reg_write_new
//                           : decode-stage operands for hazard checks
//     rd_used               : flattened slot rd array, slot i at [i*W +: W]
//     all_uu_rd_busy        : slot valid with latency countdown non-zero
//     reg_write_unit, FP_reg_write_unit : slot valid and of that class
//     raw_hazard, waw_hazard: decode hazards (no same-cycle bypass)
//     issue_reject          : combinational pulse when an issue is dropped
//   The slot field widths come from the package; rd_addr_width and
//   lat_width must stay equal to RD_ADDR_WIDTH and LAT_WIDTH.
// ---------------------------------------------------------------------------
module rd_busy_scoreboard
  import rd_busy_scoreboard_pkg::*;
#(
  parameter int num_rds       = NUM_RDS,
  parameter int rd_addr_width = RD_ADDR_WIDTH,
  parameter int lat_width     = LAT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             issue_valid,
  input  logic [$clog2(num_rds)-1:0]       issue_unit,
  input  logic [rd_addr_width-1:0]         issue_rd,
  input  logic                             issue_is_fp,
  input  logic [lat_width-1:0]             issue_latency,
  input  logic [num_rds-1:0]               wb_done,
  input  logic [num_rds-1:0]               clear_rd,
  input  logic [rd_addr_width-1:0]         rs1,
  input  logic [rd_addr_width-1:0]         rs2,
  input  logic [rd_addr_width-1:0]         rs3,
  input  logic                             rs1_is_fp,
  input  logic                             rs2_is_fp,
  input  logic                             rs3_used,
  input  logic [rd_addr_width-1:0]         new_rd,
  input  logic                             reg_write_new,
  input  logic                             FP_reg_write_new,
  output logic [num_rds*rd_addr_width-1:0] rd_used,
  output logic [num_rds-1:0]               all_uu_rd_busy,
  output logic [num_rds-1:0]               reg_write_unit,
  output logic [num_rds-1:0]               FP_reg_write_unit,
  output logic                             raw_hazard,
  output logic                             waw_hazard,
  output logic                             issue_reject
);

  localparam int UW = $clog2(num_rds);

  logic [num_rds-1:0] w_valid;
  logic [num_rds-1:0] w_is_fp;
  logic [num_rds-1:0] w_kill;
  logic [num_rds-1:0] w_hit;
  logic [num_rds-1:0] w_load;
  logic [num_rds-1:0] w_slot_reject;
  logic [num_rds-1:0] w_raw_hit;
  logic [num_rds-1:0] w_waw_hit;
  logic               w_unit_oor;

  // issue_unit is wide enough to name units that do not exist.
  assign w_unit_oor = ({{(32-UW){1'b0}}, issue_unit} >= 32'(num_rds));

  genvar gi;
  generate
    for (gi = DIV_UNIT; gi < num_rds; gi++) begin : g_slot
      logic [rd_addr_width-1:0] w_rd;

      assign w_kill[gi] = wb_done[gi] || clear_rd[gi];
      assign w_hit[gi]  = issue_valid && (issue_unit == UW'(gi));
      // A busy slot only takes a new entry when the old one leaves the
      // same cycle; otherwise the issue is dropped.
      assign w_load[gi]        = w_hit[gi] && (!w_valid[gi] || w_kill[gi]);
      assign w_slot_reject[gi] = w_hit[gi] && w_valid[gi] && !w_kill[gi];

      scoreboard_slot u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_load    (w_load[gi]),
        .i_kill    (w_kill[gi]),
        .i_rd      (issue_rd),
        .i_is_fp   (issue_is_fp),
        .i_latency (issue_latency),
        .o_valid   (w_valid[gi]),
        .o_rd      (w_rd),
        .o_is_fp   (w_is_fp[gi]),
        .o_busy    (all_uu_rd_busy[gi])
      );

      assign rd_used[gi*rd_addr_width +: rd_addr_width] = w_rd;
      assign reg_write_unit[gi]    = w_valid[gi] && !w_is_fp[gi];
      assign FP_reg_write_unit[gi] = w_valid[gi] &&  w_is_fp[gi];

      // Hazards look only at registered slot state, never at this cycle's
      // issue/writeback/clear inputs.
      assign w_raw_hit[gi] = w_valid[gi] && (
                               src_match(w_rd, w_is_fp[gi], rs1, rs1_is_fp) ||
                               src_match(w_rd, w_is_fp[gi], rs2, rs2_is_fp) ||
                               (rs3_used && src_match(w_rd, w_is_fp[gi], rs3, 1'b1)));

      assign w_waw_hit[gi] = w_valid[gi] && (
                               (reg_write_new    && src_match(w_rd, w_is_fp[gi], new_rd, 1'b0)) ||
                               (FP_reg_write_new && src_match(w_rd, w_is_fp[gi], new_rd, 1'b1)));
    end
  endgenerate

  assign raw_hazard = |w_raw_hit;
  assign waw_hazard = |w_waw_hit;

  // Gated with reset_n so every output reads 0 while reset is asserted.
  assign issue_reject = reset_n && issue_valid && (w_unit_oor || (|w_slot_reject));

endmodule

// File: tb/tb_rd_busy_scoreboard.sv
module tb_rd_busy_scoreboard;

  localparam int NR = 9;
  localparam int AW = 5;
  localparam int LW = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              issue_valid;
  logic [3:0]        issue_unit;
  logic [AW-1:0]     issue_rd;
  logic              issue_is_fp;
  logic [LW-1:0]     issue_latency;
  logic [NR-1:0]     wb_done;
  logic [NR-1:0]     clear_rd;
  logic [AW-1:0]     rs1, rs2, rs3;
  logic              rs1_is_fp, rs2_is_fp, rs3_used;
  logic [AW-1:0]     new_rd;
  logic              reg_write_new, FP_reg_write_new;
  logic [NR*AW-1:0]  rd_used;
  logic [NR-1:0]     all_uu_rd_busy;
  logic [NR-1:0]     reg_write_unit;
  logic [NR-1:0]     FP_reg_write_unit;
  logic              raw_hazard, waw_hazard, issue_reject;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  logic [63:0] obs_v;

  rd_busy_scoreboard dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .issue_valid       (issue_valid),
    .issue_unit        (issue_unit),
    .issue_rd          (issue_rd),
    .issue_is_fp       (issue_is_fp),
    .issue_latency     (issue_latency),
    .wb_done           (wb_done),
    .clear_rd          (clear_rd),
    .rs1               (rs1),
    .rs2               (rs2),
    .rs3               (rs3),
    .rs1_is_fp         (rs1_is_fp),
    .rs2_is_fp         (rs2_is_fp),
    .rs3_used          (rs3_used),
    .new_rd            (new_rd),
    .reg_write_new     (reg_write_new),
    .FP_reg_write_new  (FP_reg_write_new),
    .rd_used           (rd_used),
    .all_uu_rd_busy    (all_uu_rd_busy),
    .reg_write_unit    (reg_write_unit),
    .FP_reg_write_unit (FP_reg_write_unit),
    .raw_hazard        (raw_hazard),
    .waw_hazard        (waw_hazard),
    .issue_reject      (issue_reject)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid = 1'b0; issue_unit = '0; issue_rd = '0; issue_is_fp = 1'b0;
    issue_latency = '0; wb_done = '0; clear_rd = '0;
    rs1 = '0; rs2 = '0; rs3 = '0; rs1_is_fp = 1'b0; rs2_is_fp = 1'b0;
    rs3_used = 1'b0; new_rd = '0; reg_write_new = 1'b0; FP_reg_write_new = 1'b0;
  endtask

  task automatic drive_issue(input logic [3:0] u, input logic [AW-1:0] rd,
                             input logic fp, input logic [LW-1:0] lat);
    issue_valid = 1'b1; issue_unit = u; issue_rd = rd;
    issue_is_fp = fp; issue_latency = lat;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    drive_issue(4'd9, 5'd1, 1'b0, 5'd1);
    rs1_is_fp = 1'b1; FP_reg_write_new = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      case (k)
        0: obs_v = 64'(rd_used);
        1: obs_v = 64'(all_uu_rd_busy);
        2: obs_v = 64'(reg_write_unit);
        3: obs_v = 64'(FP_reg_write_unit);
        4: obs_v = 64'(raw_hazard);
        5: obs_v = 64'(waw_hazard);
        default: obs_v = 64'(issue_reject);
      endcase
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_v !== exp_v) begin
        n_err++; $display("FAIL reset_out%0d got %0h want %0h", k, obs_v, exp_v);
      end
    end
    @(negedge clk); idle(); reset_n = 1'b1;
    $display("reset: outputs checked under reset");
  endtask

  task automatic test_latency();
    @(negedge clk); drive_issue(4'd0, 5'd5, 1'b0, 5'd3);
    exp_q.push_back(64'd5);
    // busy for exactly 3 cycles after the issue edge, valid throughout
    exp_q.push_back(64'd1); exp_q.push_back(64'd1); exp_q.push_back(64'd1);
    exp_q.push_back(64'd0); exp_q.push_back(64'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(rd_used[4:0]) !== exp_v) begin
      n_err++; $display("FAIL lat_rd got %0d want %0d", rd_used[4:0], exp_v);
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); idle(); @(posedge clk); #1; end
      exp_v = exp_q.pop_front(); n_vec++;
      if (64'(all_uu_rd_busy[0]) !== exp_v) begin
        n_err++; $display("FAIL lat_busy c%0d got %0d want %0d", c, all_uu_rd_busy[0], exp_v);
      end
      n_vec++;
      if (reg_write_unit[0] !== 1'b1) begin
        n_err++; $display("FAIL lat_valid c%0d got %0d want 1", c, reg_write_unit[0]);
      end
    end
    @(negedge clk); idle(); wb_done[0] = 1'b1;
    exp_q.push_back({61'd0, 3'b000});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {61'd0, all_uu_rd_busy[0], reg_write_unit[0], FP_reg_write_unit[0]};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL lat_wb got %0b want %0b", obs_v, exp_v);
    end
    @(negedge clk); idle();
    $display("latency: unit0 x5 L=3 countdown and writeback checked");
  endtask

  task automatic test_raw();
    @(negedge clk); drive_issue(4'd2, 5'd7, 1'b1, 5'd4);
    rs1 = 5'd7; rs1_is_fp = 1'b1;
    exp_q.push_back(64'd0);              // no same-cycle bypass
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(raw_hazard) !== exp_v) begin
      n_err++; $display("FAIL raw_bypass got %0d want %0d", raw_hazard, exp_v);
    end
    exp_q.push_back(64'd1);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(raw_hazard) !== exp_v) begin
      n_err++; $display("FAIL raw_rs1_fp got %0d want %0d", raw_hazard, exp_v);
    end
    // rs1 int / rs2 fp / rs3 unused / rs3 used
    @(negedge clk); idle();
    for (int p = 0; p < 4; p++) begin
      idle();
      case (p)
        0: begin rs1 = 5'd7; rs1_is_fp = 1'b0; exp_q.push_back(64'd0); end
        1: begin rs2 = 5'd7; rs2_is_fp = 1'b1; exp_q.push_back(64'd1); end
        2: begin rs3 = 5'd7; rs3_used = 1'b0;  exp_q.push_back(64'd0); end
        default: begin rs3 = 5'd7; rs3_used = 1'b1; exp_q.push_back(64'd1); end
      endcase
      #1;
      exp_v = exp_q.pop_front(); n_vec++;
      if (64'(raw_hazard) !== exp_v) begin
        n_err++; $display("FAIL raw_pat%0d got %0d want %0d", p, raw_hazard, exp_v);
      end
    end
    idle(); wb_done[2] = 1'b1;
    @(posedge clk); @(negedge clk); idle();
    $display("raw: slot2 f7 against rs1/rs2/rs3 checked");
  endtask

  task automatic test_waw();
    @(negedge clk); drive_issue(4'd1, 5'd3, 1'b1, 5'd2);
    @(posedge clk); @(negedge clk); idle();
    new_rd = 5'd3;
    for (int p = 0; p < 3; p++) begin
      reg_write_new = 1'b0; FP_reg_write_new = 1'b0; clear_rd = '0;
      case (p)
        0: begin FP_reg_write_new = 1'b1; exp_q.push_back(64'd1); end
        1: begin reg_write_new = 1'b1;    exp_q.push_back(64'd0); end
        default: begin FP_reg_write_new = 1'b1; clear_rd[1] = 1'b1; exp_q.push_back(64'd1); end
      endcase
      #1;
      exp_v = exp_q.pop_front(); n_vec++;
      if (64'(waw_hazard) !== exp_v) begin
        n_err++; $display("FAIL waw_pat%0d got %0d want %0d", p, waw_hazard, exp_v);
      end
    end
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {62'd0, waw_hazard, FP_reg_write_unit[1]};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL waw_cleared got %0b want %0b", obs_v, exp_v);
    end
    @(negedge clk); idle();
    $display("waw: slot1 f3 vs new_rd 3 and clear_rd checked");
  endtask

  task automatic test_reject();
    @(negedge clk); drive_issue(4'd4, 5'd10, 1'b0, 5'd3);
    @(posedge clk); @(negedge clk); idle();
    @(posedge clk);                       // slot 4 cnt now 2
    @(negedge clk); drive_issue(4'd4, 5'd11, 1'b1, 5'd6);
    exp_q.push_back(64'd1);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(issue_reject) !== exp_v) begin
      n_err++; $display("FAIL rej_busy got %0d want %0d", issue_reject, exp_v);
    end
    // slot unchanged: rd 10, int, still busy (cnt 2 -> 1)
    exp_q.push_back({54'd0, 5'd10, 3'b101, 2'b00});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {54'd0, rd_used[20 +: 5], reg_write_unit[4], FP_reg_write_unit[4], all_uu_rd_busy[4], 2'b00};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL rej_keep got %0h want %0h", obs_v, exp_v);
    end
    @(negedge clk); drive_issue(4'd4, 5'd12, 1'b0, 5'd0); wb_done[4] = 1'b1;
    exp_q.push_back(64'd0);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(issue_reject) !== exp_v) begin
      n_err++; $display("FAIL rej_wb got %0d want %0d", issue_reject, exp_v);
    end
    // L=0: valid but never busy, and it stays valid
    exp_q.push_back({56'd0, 5'd12, 3'b100});
    exp_q.push_back({56'd0, 5'd12, 3'b100});
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front(); n_vec++;
      obs_v = {56'd0, rd_used[20 +: 5], reg_write_unit[4], FP_reg_write_unit[4], all_uu_rd_busy[4]};
      if (obs_v !== exp_v) begin
        n_err++; $display("FAIL rej_load c%0d got %0h want %0h", c, obs_v, exp_v);
      end
      @(negedge clk); idle();
    end
    drive_issue(4'd4, 5'd13, 1'b1, 5'd1); clear_rd[4] = 1'b1;
    exp_q.push_back(64'd0);
    exp_q.push_back({56'd0, 5'd13, 3'b011});
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(issue_reject) !== exp_v) begin
      n_err++; $display("FAIL rej_clr got %0d want %0d", issue_reject, exp_v);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {56'd0, rd_used[20 +: 5], reg_write_unit[4], FP_reg_write_unit[4], all_uu_rd_busy[4]};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL rej_clr_load got %0h want %0h", obs_v, exp_v);
    end
    @(negedge clk); idle(); wb_done[4] = 1'b1;
    @(posedge clk); @(negedge clk); idle();
    $display("reject: busy slot4 drop, wb/clear replacement checked");
  endtask

  task automatic test_x0();
    @(negedge clk); drive_issue(4'd0, 5'd0, 1'b0, 5'd2);
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {62'd0, reg_write_unit[0], all_uu_rd_busy[0]};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL x0_track got %0b want %0b", obs_v, exp_v);
    end
    @(negedge clk); idle(); reg_write_new = 1'b1;   // rs1/new_rd = x0
    exp_q.push_back(64'd0);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {62'd0, raw_hazard, waw_hazard};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL x0_hazard got %0b want %0b", obs_v, exp_v);
    end
    for (int u = 9; u < 16; u += 6) begin
      idle(); drive_issue(4'(u), 5'd9, 1'b0, 5'd1);
      exp_q.push_back(64'd1);
      #1;
      exp_v = exp_q.pop_front(); n_vec++;
      if (64'(issue_reject) !== exp_v) begin
        n_err++; $display("FAIL oor_unit%0d got %0d want %0d", u, issue_reject, exp_v);
      end
    end
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'({reg_write_unit, FP_reg_write_unit}) !== exp_v) begin
      n_err++; $display("FAIL oor_nochange got %0h want %0h", {reg_write_unit, FP_reg_write_unit}, exp_v);
    end
    // f0 is a real FP register and is tracked
    @(negedge clk); idle(); drive_issue(4'd3, 5'd0, 1'b1, 5'd1);
    @(posedge clk); @(negedge clk); idle(); rs1_is_fp = 1'b1;
    exp_q.push_back(64'd3);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {62'd0, FP_reg_write_unit[3], raw_hazard};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL f0_track got %0b want %0b", obs_v, exp_v);
    end
    idle(); wb_done[3] = 1'b1;
    @(posedge clk); @(negedge clk); idle();
    $display("x0: untracked x0, tracked f0, out-of-range unit checked");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); drive_issue(4'd0, 5'd1, 1'b0, 5'd5);
    @(posedge clk); @(negedge clk); drive_issue(4'd3, 5'd2, 1'b1, 5'd5);
    @(posedge clk); @(negedge clk); drive_issue(4'd8, 5'd31, 1'b0, 5'd5);
    exp_q.push_back({27'd0, 9'h101, 9'h008, 9'h109, 5'd0, 5'd31});
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {27'd0, reg_write_unit, FP_reg_write_unit, all_uu_rd_busy, 5'd0, rd_used[40 +: 5]};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL b2b_state got %0h want %0h", obs_v, exp_v);
    end
    @(negedge clk); idle(); rs1 = 5'd1;
    exp_q.push_back(64'd1);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    if (64'(raw_hazard) !== exp_v) begin
      n_err++; $display("FAIL b2b_raw got %0d want %0d", raw_hazard, exp_v);
    end
    #1 reset_n = 1'b0;                     // mid-cycle, no clock edge
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {18'd0, rd_used, raw_hazard};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL async_rst_rd got %0h want %0h", obs_v, exp_v);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {37'd0, reg_write_unit, FP_reg_write_unit, all_uu_rd_busy};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL async_rst_flags got %0h want %0h", obs_v, exp_v);
    end
    #1 reset_n = 1'b1;
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front(); n_vec++;
    obs_v = {18'd0, rd_used, reg_write_unit[0]} | {37'd0, FP_reg_write_unit, all_uu_rd_busy, 9'd0};
    if (obs_v !== exp_v) begin
      n_err++; $display("FAIL post_rst got %0h want %0h", obs_v, exp_v);
    end
    @(negedge clk); idle();
    $display("back_to_back: slots 0/3/8 filled then async reset checked");
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_latency();
    test_raw();
    test_waw();
    test_reject();
    test_x0();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL queue_drain got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
